sh_exc_seq: RTL and testbench

- CPU-side responder to the SH7034 interrupt controller: consumes INT_REQ/INT_LVL/INT_VEC and returns INT_MASK, INT_ACK, INT_ACP and VECT_REQ.
- Runs the exception entry sequence: acknowledge, vector handshake, push SR and PC to the stack, fetch the handler address from VBR+vec*4, load the new PC/SP/SR.I.
- Sits between the core pipeline control and the internal bus; the core stalls while BUSY=1.

---
 rtl/sh_exc_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_sh_exc_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sh_exc_seq.sv
// sh_exc_seq -- exception entry sequencer facing the SH7034 interrupt controller.
//
// Accepts an interrupt at an instruction boundary and performs these steps:
// acknowledge, vector handshake, push SR then PC below SP, fetch the handler
// address from VBR+vec*4, then pulse LOAD so the core picks up
// NEW_PC/NEW_SP/NEW_I. The core stalls while BUSY=1.
//
// Ports:
//   CLK, RST_N (async, active-low), CE_R (rising-phase enable, all state),
//   CE_F (falling-phase enable, only used to sample VECT_WAIT)
//   INT_REQ/INT_LVL/INT_VEC/VECT_WAIT  : from interrupt controller
//   INT_MASK/INT_ACK/INT_ACP/VECT_REQ  : to interrupt controller
//   INST_BND, SR_IN, PC_IN, SP_IN, VBR_IN : core state
//   BUS_A/BUS_DO/BUS_WE/BUS_REQ, BUS_DI/BUS_BUSY : internal bus master
//   BUSY, LOAD, NEW_PC, NEW_SP, NEW_I : core control
//
// Optional build macro SH_EXC_SPALIGN_EN: when defined, an unaligned stacked SP
// skips both pushes and vectors to the address-error handler (vector 9) with
// SP left unchanged.

module sh_exc_seq #(
    parameter int VEC_W  = 8,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE_R,
    input  logic              CE_F,
    input  logic              INT_REQ,
    input  logic [3:0]        INT_LVL,
    input  logic [VEC_W-1:0]  INT_VEC,
    input  logic              VECT_WAIT,
    input  logic              INST_BND,
    input  logic [31:0]       SR_IN,
    input  logic [ADDR_W-1:0] PC_IN,
    input  logic [ADDR_W-1:0] SP_IN,
    input  logic [ADDR_W-1:0] VBR_IN,
    output logic [3:0]        INT_MASK,
    output logic              INT_ACK,
    output logic              INT_ACP,
    output logic              VECT_REQ,
    output logic [ADDR_W-1:0] BUS_A,
    output logic [31:0]       BUS_DO,
    input  logic [31:0]       BUS_DI,
    output logic              BUS_WE,
    output logic              BUS_REQ,
    input  logic              BUS_BUSY,
    output logic              BUSY,
    output logic              LOAD,
    output logic [ADDR_W-1:0] NEW_PC,
    output logic [ADDR_W-1:0] NEW_SP,
    output logic [3:0]        NEW_I
);

    typedef enum logic [2:0] {
        S_IDLE, S_VECT, S_VWAIT, S_PSR, S_PPC, S_FETCH, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        lvl_q, lvl_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [31:0]       sr_q, sr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              ack_q, ack_d;
    logic              acp_q, acp_d;
    logic              load_q, load_d;
    logic [ADDR_W-1:0] new_pc_q, new_pc_d;
    logic [ADDR_W-1:0] new_sp_q, new_sp_d;
    logic [3:0]        new_i_q, new_i_d;
    logic              vwait_q, vwait_d;
`ifdef SH_EXC_SPALIGN_EN
    logic              aerr_q, aerr_d;
`endif

    logic              accept;
    logic              bus_done;
    logic [ADDR_W-1:0] fetch_a;

    // Level 15 (NMI) is accepted even against a mask of 15.
    assign accept   = INT_REQ & INST_BND &
                      ((INT_LVL > SR_IN[7:4]) | (INT_LVL == 4'hF));
    assign bus_done = CE_R & ~BUS_BUSY;
    assign fetch_a  = VBR_IN + {{(ADDR_W-VEC_W-2){1'b0}}, vec_q, 2'b00};

    assign INT_MASK = SR_IN[7:4];
    assign INT_ACK  = ack_q;
    assign INT_ACP  = acp_q;
    assign LOAD     = load_q;
    assign NEW_PC   = new_pc_q;
    assign NEW_SP   = new_sp_q;
    assign NEW_I    = new_i_q;
    // Combinational from state so an async reset drops them at once.
    assign BUSY     = (state_q != S_IDLE);
    assign VECT_REQ = (state_q == S_VECT);

    // Bus drive: a pure function of state and latched context, so address
    // and data stay put for as long as BUS_BUSY stretches an access.
    always_comb begin
        BUS_REQ = 1'b0;
        BUS_WE  = 1'b0;
        BUS_A   = '0;
        BUS_DO  = '0;
        case (state_q)
            S_PSR: begin
`ifdef SH_EXC_SPALIGN_EN
                if (sp_q[1:0] == 2'b00) begin
                    BUS_REQ = 1'b1;
                    BUS_WE  = 1'b1;
                    BUS_A   = sp_q - ADDR_W'(4);
                    BUS_DO  = sr_q;
                end
`else
                BUS_REQ = 1'b1;
                BUS_WE  = 1'b1;
                BUS_A   = sp_q - ADDR_W'(4);
                BUS_DO  = sr_q;
`endif
            end
            S_PPC: begin
                BUS_REQ = 1'b1;
                BUS_WE  = 1'b1;
                BUS_A   = sp_q - ADDR_W'(8);
                BUS_DO  = 32'(pc_q);
            end
            S_FETCH: begin
                BUS_REQ = 1'b1;
                BUS_A   = fetch_a;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        vec_d    = vec_q;
        sr_d     = sr_q;
        pc_d     = pc_q;
        sp_d     = sp_q;
        ack_d    = ack_q;
        acp_d    = acp_q;
        load_d   = load_q;
        new_pc_d = new_pc_q;
        new_sp_d = new_sp_q;
        new_i_d  = new_i_q;
        // VECT_WAIT is captured on the falling phase, used on the rising one.
        vwait_d  = CE_F ? VECT_WAIT : vwait_q;
`ifdef SH_EXC_SPALIGN_EN
        aerr_d   = aerr_q;
`endif
        if (CE_R) begin
            // Pulses last exactly one enabled cycle.
            ack_d  = 1'b0;
            load_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        lvl_d   = INT_LVL;
                        vec_d   = INT_VEC;
                        sr_d    = SR_IN;
                        pc_d    = PC_IN;
                        sp_d    = SP_IN;
                        ack_d   = 1'b1;
                        acp_d   = 1'b1;
`ifdef SH_EXC_SPALIGN_EN
                        aerr_d  = 1'b0;
`endif
                        state_d = S_VECT;
                    end
                end
                S_VECT:  state_d = S_VWAIT;
                S_VWAIT: if (!vwait_q) state_d = S_PSR;
                S_PSR: begin
`ifdef SH_EXC_SPALIGN_EN
                    if (sp_q[1:0] != 2'b00) begin
                        vec_d   = VEC_W'(9);
                        aerr_d  = 1'b1;
                        state_d = S_FETCH;
                    end else if (!BUS_BUSY) begin
                        state_d = S_PPC;
                    end
`else
                    if (bus_done) state_d = S_PPC;
`endif
                end
                S_PPC: if (bus_done) state_d = S_FETCH;
                S_FETCH: begin
                    if (bus_done) begin
                        new_pc_d = ADDR_W'(BUS_DI);
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    load_d   = 1'b1;
                    acp_d    = 1'b0;
                    new_i_d  = lvl_q;
`ifdef SH_EXC_SPALIGN_EN
                    new_sp_d = aerr_q ? sp_q : sp_q - ADDR_W'(8);
`else
                    new_sp_d = sp_q - ADDR_W'(8);
`endif
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            lvl_q    <= '0;
            vec_q    <= '0;
            sr_q     <= '0;
            pc_q     <= '0;
            sp_q     <= '0;
            ack_q    <= 1'b0;
            acp_q    <= 1'b0;
            load_q   <= 1'b0;
            new_pc_q <= '0;
            new_sp_q <= '0;
            new_i_q  <= '0;
            // Treat the controller as busy until it has actually been sampled.
            vwait_q  <= 1'b1;
`ifdef SH_EXC_SPALIGN_EN
            aerr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            vec_q    <= vec_d;
            sr_q     <= sr_d;
            pc_q     <= pc_d;
            sp_q     <= sp_d;
            ack_q    <= ack_d;
            acp_q    <= acp_d;
            load_q   <= load_d;
            new_pc_q <= new_pc_d;
            new_sp_q <= new_sp_d;
            new_i_q  <= new_i_d;
            vwait_q  <= vwait_d;
`ifdef SH_EXC_SPALIGN_EN
            aerr_q   <= aerr_d;
`endif
        end
    end

endmodule

// File: tb/tb_sh_exc_seq.sv
// Directed testbench for sh_exc_seq. A small bus slave returns 0x4000 at
// address 0x100 and addr+0x10000 elsewhere; a negedge monitor logs pulses,
// bus writes/reads and address/data stability under wait states.
module tb_sh_exc_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1, ce_r = 1'b1, ce_f = 1'b1;
    logic        int_req = 1'b0, vect_wait = 1'b0, inst_bnd = 1'b1;
    logic [3:0]  int_lvl = '0;
    logic [7:0]  int_vec = '0;
    logic [31:0] sr_in = '0, pc_in = '0, sp_in = '0, vbr_in = '0;
    logic [3:0]  int_mask, new_i;
    logic        int_ack, int_acp, vect_req, bus_we, bus_req, bus_busy, busy, load;
    logic [31:0] bus_a, bus_do, bus_di, new_pc, new_sp;

    sh_exc_seq dut (
        .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .CE_F(ce_f),
        .INT_REQ(int_req), .INT_LVL(int_lvl), .INT_VEC(int_vec),
        .VECT_WAIT(vect_wait), .INST_BND(inst_bnd),
        .SR_IN(sr_in), .PC_IN(pc_in), .SP_IN(sp_in), .VBR_IN(vbr_in),
        .INT_MASK(int_mask), .INT_ACK(int_ack), .INT_ACP(int_acp),
        .VECT_REQ(vect_req), .BUS_A(bus_a), .BUS_DO(bus_do), .BUS_DI(bus_di),
        .BUS_WE(bus_we), .BUS_REQ(bus_req), .BUS_BUSY(bus_busy), .BUSY(busy),
        .LOAD(load), .NEW_PC(new_pc), .NEW_SP(new_sp), .NEW_I(new_i)
    );

    int checks = 0, failures = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h100) ? 32'h4000 : a + 32'h10000;
    endfunction
    assign bus_di = mem_rd(bus_a);

    // Wait-state generator: each access is held busy for nwait cycles.
    int nwait = 0, wcnt = 0;
    assign bus_busy = bus_req && (wcnt < nwait);
    always @(posedge clk) begin
        if (!bus_req || !bus_busy) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
    end

    // Monitor
    logic        clr_req = 1'b0;
    int          cyc = 0, ack_n = 0, ack_at = 0, load_n = 0, load_at = 0;
    int          nwr = 0, nrd = 0, breq_n = 0, busy_n = 0, unstable = 0;
    logic [31:0] wa [4], wd [4];
    logic [31:0] ra = '0, pa = '0, pd = '0;
    logic        pw = 1'b0, pheld = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (clr_req) begin
            ack_n <= 0; load_n <= 0; nwr <= 0; nrd <= 0; breq_n <= 0;
            busy_n <= 0; unstable <= 0; pheld <= 1'b0;
        end else begin
            if (int_ack) begin ack_n <= ack_n + 1; ack_at <= cyc; end
            if (load)    begin load_n <= load_n + 1; load_at <= cyc; end
            if (busy)    busy_n <= busy_n + 1;
            if (bus_req) breq_n <= breq_n + 1;
            if (bus_req && pheld && (bus_a !== pa || bus_do !== pd || bus_we !== pw))
                unstable <= unstable + 1;
            if (bus_req && !bus_busy) begin
                if (bus_we) begin
                    if (nwr < 4) begin wa[nwr] <= bus_a; wd[nwr] <= bus_do; end
                    nwr <= nwr + 1;
                end else begin
                    ra <= bus_a; nrd <= nrd + 1;
                end
            end
            pheld <= bus_req && bus_busy;
            pa <= bus_a; pd <= bus_do; pw <= bus_we;
        end
    end

    task automatic clr();
        @(posedge clk); #1 clr_req = 1'b1;
        @(negedge clk); #1 clr_req = 1'b0;
    endtask

    // Raise INT_REQ, drop it once acknowledged, wait for LOAD.
    task automatic do_seq(input int budget);
        bit done = 1'b0;
        clr();
        int_req = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int_ack) int_req = 1'b0;
            if (load) begin done = 1'b1; break; end
        end
        int_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (!done) begin failures++; $display("FAIL seq_timeout: no LOAD within %0d cycles", budget); end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        // only used for formatting-free reuse is avoided; see inline checks
    endtask

    task automatic test_reset();
        sr_in = 32'h50;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({int_ack, int_acp, vect_req, bus_req, bus_we, busy, load} !== 7'b0 ||
            new_pc !== 32'h0 || new_sp !== 32'h0 || new_i !== 4'h0 || bus_a !== 32'h0) begin
            failures++; $display("FAIL reset_outputs: ack=%b acp=%b breq=%b busy=%b load=%b pc=%h sp=%h i=%h, required all 0",
                                 int_ack, int_acp, bus_req, busy, load, new_pc, new_sp, new_i);
        end
        checks++;
        if (int_mask !== 4'h5) begin failures++; $display("FAIL reset_mask: got %h required 5", int_mask); end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        nwait = 0; sr_in = 32'h30; int_lvl = 4'd5; int_vec = 8'd64; vbr_in = 32'h0;
        sp_in = 32'h1000; pc_in = 32'h200;
        do_seq(50);
        checks++;
        if (ack_n !== 1) begin failures++; $display("FAIL basic_ack_count: got %0d required 1", ack_n); end
        checks++;
        if (load_at - ack_at !== 6) begin failures++; $display("FAIL basic_latency: got %0d required 6", load_at - ack_at); end
        checks++;
        if (nwr !== 2 || wa[0] !== 32'hFFC || wd[0] !== 32'h30 || wa[1] !== 32'hFF8 || wd[1] !== 32'h200) begin
            failures++; $display("FAIL basic_writes: n=%0d %h<-%h %h<-%h required 2 FFC<-30 FF8<-200", nwr, wa[0], wd[0], wa[1], wd[1]);
        end
        checks++;
        if (nrd !== 1 || ra !== 32'h100) begin failures++; $display("FAIL basic_read: n=%0d a=%h required 1 100", nrd, ra); end
        checks++;
        if (new_pc !== 32'h4000 || new_sp !== 32'hFF8 || new_i !== 4'h5) begin
            failures++; $display("FAIL basic_load: pc=%h sp=%h i=%h required 4000 FF8 5", new_pc, new_sp, new_i);
        end
        checks++;
        if (busy !== 1'b0 || int_acp !== 1'b0 || load !== 1'b0) begin
            failures++; $display("FAIL basic_idle: busy=%b acp=%b load=%b required 0 0 0", busy, int_acp, load);
        end
    endtask

    task automatic test_mask_nmi();
        sr_in = 32'h70; int_lvl = 4'd5; int_vec = 8'd11; vbr_in = 32'h0;
        sp_in = 32'h2000; pc_in = 32'h300;
        clr();
        int_req = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (ack_n !== 0 || busy_n !== 0 || busy !== 1'b0) begin
            failures++; $display("FAIL mask_block: acks=%0d busy_cycles=%0d required 0 0", ack_n, busy_n);
        end
        int_req = 1'b0;
        int_lvl = 4'hF;
        do_seq(50);
        checks++;
        if (ack_n !== 1 || new_i !== 4'hF || new_pc !== 32'h1002C || new_sp !== 32'h1FF8) begin
            failures++; $display("FAIL nmi_accept: acks=%0d i=%h pc=%h sp=%h required 1 F 1002C 1FF8", ack_n, new_i, new_pc, new_sp);
        end
    endtask

    task automatic test_bus_wait();
        nwait = 3; sr_in = 32'h20; int_lvl = 4'd6; int_vec = 8'd16; vbr_in = 32'h8000;
        sp_in = 32'h3000; pc_in = 32'h444;
        do_seq(80);
        nwait = 0;
        checks++;
        if (load_at - ack_at !== 15) begin failures++; $display("FAIL wait_latency: got %0d required 15", load_at - ack_at); end
        checks++;
        if (unstable !== 0) begin failures++; $display("FAIL wait_stable: changes=%0d required 0", unstable); end
        checks++;
        if (nwr !== 2 || wa[0] !== 32'h2FFC || wd[0] !== 32'h20 || wa[1] !== 32'h2FF8 || wd[1] !== 32'h444) begin
            failures++; $display("FAIL wait_writes: n=%0d %h<-%h %h<-%h required 2 2FFC<-20 2FF8<-444", nwr, wa[0], wd[0], wa[1], wd[1]);
        end
        checks++;
        if (ra !== 32'h8040 || new_pc !== 32'h18040) begin
            failures++; $display("FAIL wait_fetch: a=%h pc=%h required 8040 18040", ra, new_pc);
        end
    endtask

    task automatic test_vect_wait();
        bit done = 1'b0;
        sr_in = 32'h0; int_lvl = 4'd2; int_vec = 8'd32; vbr_in = 32'h0;
        sp_in = 32'h1000; pc_in = 32'h600;
        vect_wait = 1'b1;
        clr();
        int_req = 1'b1;
        for (int i = 0; i < 20 && !vect_req; i++) @(negedge clk);
        int_req = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (breq_n !== 0 || int_acp !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL vwait_hold: breq_cycles=%0d acp=%b busy=%b required 0 1 1", breq_n, int_acp, busy);
        end
        #1 vect_wait = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (load) begin done = 1'b1; break; end
        end
        @(posedge clk); #1;
        checks++;
        if (!done || ack_n !== 1 || nwr !== 2 || new_pc !== 32'h10080) begin
            failures++; $display("FAIL vwait_complete: load=%b acks=%0d writes=%0d pc=%h required 1 1 2 10080", done, ack_n, nwr, new_pc);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        sr_in = 32'h10; int_lvl = 4'd3; int_vec = 8'd64; vbr_in = 32'h0;
        sp_in = 32'h5000; pc_in = 32'h700;
        clr();
        int_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (int_ack) int_req = 1'b0;
            if (bus_req && bus_we && bus_a == 32'h4FF8) begin hit = 1'b1; break; end
        end
        int_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (!hit || bus_req !== 1'b0 || busy !== 1'b0 || int_acp !== 1'b0 || load !== 1'b0) begin
            failures++; $display("FAIL rst_mid: reached_ppc=%b breq=%b busy=%b acp=%b load=%b required 1 0 0 0 0",
                                 hit, bus_req, busy, int_acp, load);
        end
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (load_n !== 0 || busy !== 1'b0) begin failures++; $display("FAIL rst_no_load: loads=%0d busy=%b required 0 0", load_n, busy); end
        do_seq(50);
        checks++;
        if (ack_n !== 1 || new_pc !== 32'h4000 || new_sp !== 32'h4FF8 || new_i !== 4'h3) begin
            failures++; $display("FAIL rst_fresh: acks=%0d pc=%h sp=%h i=%h required 1 4000 4FF8 3", ack_n, new_pc, new_sp, new_i);
        end
    endtask

    task automatic test_wrap();
        sr_in = 32'hF0; int_lvl = 4'hF; int_vec = 8'd4; vbr_in = 32'hFFFFFFF0;
        sp_in = 32'h0; pc_in = 32'h800;
        do_seq(50);
        checks++;
        if (nwr !== 2 || wa[0] !== 32'hFFFFFFFC || wa[1] !== 32'hFFFFFFF8) begin
            failures++; $display("FAIL wrap_writes: n=%0d %h %h required 2 FFFFFFFC FFFFFFF8", nwr, wa[0], wa[1]);
        end
        checks++;
        if (ra !== 32'h0 || new_pc !== 32'h10000 || new_sp !== 32'hFFFFFFF8) begin
            failures++; $display("FAIL wrap_fetch: a=%h pc=%h sp=%h required 0 10000 FFFFFFF8", ra, new_pc, new_sp);
        end
    endtask

    task automatic test_unaligned();
        sr_in = 32'h0; int_lvl = 4'd4; int_vec = 8'd64; vbr_in = 32'h20000;
        sp_in = 32'h1002; pc_in = 32'h900;
        do_seq(50);
`ifdef SH_EXC_SPALIGN_EN
        checks++;
        if (nwr !== 0 || ra !== 32'h20024 || new_pc !== 32'h30024 || new_sp !== 32'h1002 || new_i !== 4'h4) begin
            failures++; $display("FAIL unaligned_aerr: writes=%0d a=%h pc=%h sp=%h i=%h required 0 20024 30024 1002 4",
                                 nwr, ra, new_pc, new_sp, new_i);
        end
`else
        checks++;
        if (nwr !== 2 || wa[0] !== 32'hFFE || wa[1] !== 32'hFFA || ra !== 32'h20100 || new_sp !== 32'hFFA) begin
            failures++; $display("FAIL unaligned_push: n=%0d %h %h a=%h sp=%h required 2 FFE FFA 20100 FFA",
                                 nwr, wa[0], wa[1], ra, new_sp);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask_nmi();
        test_bus_wait();
        test_vect_wait();
        test_reset_mid();
        test_wrap();
        test_unaligned();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
